// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scan controller: digit limits,
// scan FSM encoding and the active-low hex-to-segment table (bit7 = dp).
package smg_pkg;

  localparam int NUM_DIGITS_MIN = 2;
  localparam int NUM_DIGITS_MAX = 8;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_DARK = 8'hFF;

  // Index 0 is the rightmost entry of the literal, i.e. hex digit 0.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// Load handshake and display-drive signals of the scan controller; the
// master side offers values, the slave side is the controller itself.
interface smg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);

  logic                    Load_Valid;
  logic                    Load_Ready;
  logic [4*NUM_DIGITS-1:0] Load_Data;
  logic [NUM_DIGITS-1:0]   Blank_Mask;
  logic                    Lz_En;
  logic [7:0]              SMG_Data;
  logic [NUM_DIGITS-1:0]   Scan_Sel;

  modport master (
    output Load_Valid, Load_Data, Blank_Mask, Lz_En,
    input  Load_Ready, SMG_Data, Scan_Sel
  );

  modport slave (
    input  Load_Valid, Load_Data, Blank_Mask, Lz_En,
    output Load_Ready, SMG_Data, Scan_Sel
  );

endinterface

// File: rtl/smg_encode_module.sv
// Registered nibble-to-segment encoder; a dark digit drives all segments off.
module smg_encode_module
  import smg_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] seg
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      seg <= SEG_DARK;
    end else begin
      seg <= blank ? SEG_DARK : hex_to_seg(nib);
    end
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered display value,
// per-slot blank/show FSM and leading-zero / mask suppression.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2
)(
  input  logic             CLK,
  input  logic             RSTn,
  smg_scan_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SHOW_START = CNT_W'(SCAN_DIV - BLANK_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   scan_sel;

  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_mask;
  logic                    pend_lz;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_mask;
  logic                    disp_lz;

  logic                    slot_end;
  logic                    xfer;
  logic                    load_ready;
  logic                    load_fire;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic [7:0]              seg_q;

  assign slot_end   = (cnt == '0);
  // The pending slot frees up on the frame-boundary edge, so a new value may land then.
  assign xfer       = (state == ST_SHOW) && slot_end && (idx == LAST_IDX) && pend_full;
  assign load_ready = !pend_full || xfer;
  assign load_fire  = bus.Load_Valid && load_ready;
  assign cur_nib    = disp_data[{idx, 2'b00} +: 4];

  always_comb begin
    suppress   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (disp_data[4*i +: 4] == 4'h0);
      suppress[i] = disp_mask[i] || (disp_lz && zero_above && (i != 0));
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_mask <= '0;
      pend_lz   <= 1'b0;
      disp_data <= '0;
      disp_mask <= '1;
      disp_lz   <= 1'b0;
    end else begin
      if (xfer) begin
        disp_data <= pend_data;
        disp_mask <= pend_mask;
        disp_lz   <= pend_lz;
      end
      if (load_fire) begin
        pend_data <= bus.Load_Data;
        pend_mask <= bus.Blank_Mask;
        pend_lz   <= bus.Lz_En;
        pend_full <= 1'b1;
      end else if (xfer) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_BLANK;
      cnt      <= CNT_TOP;
      idx      <= '0;
      scan_sel <= '1;
    end else begin
      cnt <= slot_end ? CNT_TOP : cnt - CNT_W'(1);
      unique case (state)
        ST_BLANK: begin
          if (cnt == SHOW_START) begin
            state    <= ST_SHOW;
            scan_sel <= suppress[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
          end
        end
        ST_SHOW: begin
          if (slot_end) begin
            state    <= ST_BLANK;
            scan_sel <= '1;
            idx      <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  smg_encode_module u_encode (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .nib   (cur_nib),
    .blank (suppress[idx]),
    .seg   (seg_q)
  );

  assign bus.Load_Ready = load_ready;
  assign bus.SMG_Data   = seg_q;
  assign bus.Scan_Sel   = scan_sel;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl with 4 digits, 4-cycle slots and 1 blank cycle;
// accepted loads queue as expected frames and are popped at each frame boundary.
module tb_smg_scan_ctrl;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      mask;
    logic            lz;
    logic [3:0][7:0] seg;
    logic [3:0]      vis;
  } vec_t;

  logic CLK;
  logic RSTn;

  smg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  smg_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLANK_CYC  (1)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  vec_t tbl [8];
  vec_t rst_rec;
  vec_t disp;
  vec_t cur;
  vec_t exp_q [$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot timing is derived purely from the cycle count since reset release.
  task automatic check_output();
    int         ph;
    int         dg;
    logic [3:0] es;
    bit         rdy;
    ph  = cyc % 4;
    dg  = (cyc / 4) % 4;
    es  = (ph == 0 || !disp.vis[dg]) ? 4'hF : ~(4'b0001 << dg);
    rdy = (exp_q.size() == 0) || ((cyc % 16) == 15);
    check("scan_sel", 32'(bus.Scan_Sel), 32'(es));
    if (ph != 0 && disp.vis[dg]) check("smg_data", 32'(bus.SMG_Data), 32'(disp.seg[dg]));
    check("load_ready", 32'(bus.Load_Ready), 32'(rdy));
  endtask

  task automatic apply_stimulus(output bit hs);
    bit rdy;
    rdy = (exp_q.size() == 0) || ((cyc % 16) == 15);
    hs  = bus.Load_Valid && rdy;
    @(posedge CLK);
    if ((cyc % 16) == 15 && exp_q.size() > 0) disp = exp_q.pop_front();
    if (hs) exp_q.push_back(cur);
    cyc++;
    @(negedge CLK);
    check_output();
  endtask

  task automatic run_cycles(input int n);
    bit hs;
    for (int k = 0; k < n; k++) apply_stimulus(hs);
  endtask

  task automatic advance_to(input int slot_pos);
    bit hs;
    for (int k = 0; k < 16 && (cyc % 16) != slot_pos; k++) apply_stimulus(hs);
  endtask

  task automatic drive_load(input vec_t v);
    cur            = v;
    bus.Load_Data  = v.data;
    bus.Blank_Mask = v.mask;
    bus.Lz_En      = v.lz;
    bus.Load_Valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit hs;
    hs = 1'b0;
    for (int k = 0; k < 40 && !hs; k++) apply_stimulus(hs);
    check(name, 32'(hs), 32'd1);
  endtask

  task automatic do_reset();
    RSTn           = 1'b0;
    bus.Load_Valid = 1'b0;
    #1;
    check("rst_sel_now", 32'(bus.Scan_Sel), 32'hF);
    check("rst_seg_now", 32'(bus.SMG_Data), 32'hFF);
    check("rst_ready_now", 32'(bus.Load_Ready), 32'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_sel_hold", 32'(bus.Scan_Sel), 32'hF);
    check("rst_seg_hold", 32'(bus.SMG_Data), 32'hFF);
    RSTn = 1'b1;
    cyc  = 0;
    disp = rst_rec;
    exp_q.delete();
    check_output();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111};
    tbl[1] = '{16'h0005, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h92}, 4'b0001};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001};
    tbl[3] = '{16'hABCD, 4'b0100, 1'b0, {8'h88, 8'hFF, 8'hC6, 8'hA1}, 4'b1011};
    tbl[4] = '{16'h0F07, 4'b0000, 1'b1, {8'hFF, 8'h8E, 8'hC0, 8'hF8}, 4'b0111};
    tbl[5] = '{16'h0080, 4'b1000, 1'b0, {8'hFF, 8'hC0, 8'h80, 8'hC0}, 4'b0111};
    tbl[6] = '{16'h6009, 4'b0000, 1'b1, {8'h82, 8'hC0, 8'hC0, 8'h90}, 4'b1111};
    tbl[7] = '{16'hE00B, 4'b0001, 1'b0, {8'h86, 8'hC0, 8'hC0, 8'hFF}, 4'b1110};
    rst_rec = '{16'h0000, 4'b1111, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000};

    RSTn           = 1'b1;
    bus.Load_Valid = 1'b0;
    bus.Load_Data  = '0;
    bus.Blank_Mask = '0;
    bus.Lz_En      = 1'b0;
    #2;
    do_reset();
    run_cycles(8);

    for (int i = 0; i < 8; i++) begin
      drive_load(tbl[i]);
      wait_accept("tbl_accept");
      bus.Load_Valid = 1'b0;
      run_cycles(40);
    end

    // Load during digit 2: digit 3 keeps the old value, digit 0 shows the new one.
    advance_to(8);
    drive_load(tbl[0]);
    wait_accept("fb_accept");
    bus.Load_Valid = 1'b0;
    advance_to(13);
    check("fb_old_d3", 32'(bus.SMG_Data), 32'h86);
    advance_to(1);
    check("fb_new_d0", 32'(bus.SMG_Data), 32'h99);
    run_cycles(16);

    // Two back-to-back values with Load_Valid held high.
    advance_to(4);
    drive_load(tbl[1]);
    wait_accept("bp_first_accept");
    check("bp_ready_low", 32'(bus.Load_Ready), 32'd0);
    drive_load(tbl[6]);
    wait_accept("bp_second_accept");
    check("bp_accept_slot", 32'(cyc % 16), 32'd0);
    bus.Load_Valid = 1'b0;
    advance_to(1);
    check("bp_first_d0", 32'(bus.SMG_Data), 32'h92);
    advance_to(0);
    advance_to(13);
    check("bp_second_d3", 32'(bus.SMG_Data), 32'h82);

    // Reset in the middle of a visible digit slot.
    advance_to(6);
    check("pre_rst_sel", 32'(bus.Scan_Sel), 32'hD);
    do_reset();
    run_cycles(20);
    drive_load(tbl[3]);
    wait_accept("post_rst_accept");
    bus.Load_Valid = 1'b0;
    run_cycles(40);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
